// File: rtl/reduce_pkg.sv
// rtl/reduce_pkg.sv - shared op encoding, identity/combine helpers and tree-geometry functions
package reduce_pkg;

  typedef enum logic [1:0] {
    OP_AND    = 2'd0,
    OP_OR     = 2'd1,
    OP_XOR    = 2'd2,
    OP_OR_ALT = 2'd3
  } op_e;

  function automatic logic identity(input op_e op);
    return (op == OP_AND);
  endfunction

  function automatic logic combine(input op_e op, input logic a, input logic b);
    case (op)
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return a | b;
    endcase
  endfunction

  // Bits present at tree level `level` (level 0 is the raw input word).
  function automatic int level_width(input int width, input int fanin, input int level);
    int w;
    w = width;
    for (int i = 0; i < level; i++) w = (w + fanin - 1) / fanin;
    return w;
  endfunction

  function automatic int stage_count(input int width, input int fanin);
    int w;
    int n;
    w = width;
    n = 0;
    while (w > 1) begin
      w = (w + fanin - 1) / fanin;
      n++;
    end
    return n;
  endfunction

  // Start bit of level `level` when all levels are packed into one flat bus.
  function automatic int level_offset(input int width, input int fanin, input int level);
    int s;
    s = 0;
    for (int i = 0; i < level; i++) s += level_width(width, fanin, i);
    return s;
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// rtl/reduce_stage.sv - one registered reduction tree level with a skid-free valid/ready slice
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int FANIN = 4,
  parameter bit LAST  = 1'b0,
  parameter bit ACCUM = 1'b0,
  localparam int OUT_W = (IN_W + FANIN - 1) / FANIN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_op,
  input  logic             in_inv,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_op,
  output logic             out_inv,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int PAD_W = OUT_W * FANIN;

  op_e              op;
  logic             ident;
  logic [PAD_W-1:0] padded;
  logic [OUT_W-1:0] nodes;
  logic [OUT_W-1:0] next_data;
  logic             folded;
  logic             emit;
  logic             acc_q;
  logic             open_q;

  assign in_ready = !out_valid || out_ready;

  always_comb begin
    op     = op_e'(in_op);
    ident  = identity(op);
    padded = {PAD_W{ident}};
    padded[IN_W-1:0] = in_data;
    nodes  = '0;
    for (int j = 0; j < OUT_W; j++) begin
      nodes[j] = ident;
      for (int b = 0; b < FANIN; b++) nodes[j] = combine(op, nodes[j], padded[j*FANIN+b]);
    end
    // Only the final level folds in the running packet value and applies inversion.
    folded    = (ACCUM && open_q) ? combine(op, acc_q, nodes[0]) : nodes[0];
    next_data = nodes;
    if (LAST) next_data[0] = folded ^ in_inv;
    emit = !(LAST && ACCUM) || in_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= '0;
      out_inv   <= 1'b0;
      out_last  <= 1'b0;
      acc_q     <= 1'b0;
      open_q    <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid && emit;
      if (in_valid) begin
        out_data <= next_data;
        out_op   <= in_op;
        out_inv  <= in_inv;
        out_last <= in_last;
        if (LAST && ACCUM) begin
          acc_q  <= folded;
          open_q <= !in_last;
        end
      end
    end
  end

endmodule

// File: rtl/reduce_pipe.sv
// rtl/reduce_pipe.sv - pipelined FANIN-ary AND/OR/XOR reducer with valid/ready streams
// Define REDUCE_PIPE_ACCUM_EN to add I_last and fold whole packets into one result.
module reduce_pipe
  import reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FANIN = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  input  logic [1:0]       OP,
  input  logic             INV,
`ifdef REDUCE_PIPE_ACCUM_EN
  input  logic             I_last,
`endif
  input  logic             I_valid,
  output logic             I_ready,
  output logic             O,
  output logic             O_valid,
  input  logic             O_ready
);

  localparam int STAGES = stage_count(WIDTH, FANIN);
  localparam int BUS_W  = level_offset(WIDTH, FANIN, STAGES + 1);
`ifdef REDUCE_PIPE_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif

  // All tree levels share one flat bus; level k starts at level_offset(k).
  logic [BUS_W-1:0] data_bus;
  logic [STAGES:0]  valid_c;
  logic [STAGES:0]  ready_c;
  logic [STAGES:0]  inv_c;
  logic [STAGES:0]  last_c;
  logic [1:0]       op_c [0:STAGES];
  logic [3:0]       tail_ctl_unused;

  assign data_bus[WIDTH-1:0] = I;
  assign op_c[0]             = OP;
  assign inv_c[0]            = INV;
  assign valid_c[0]          = I_valid;
  assign I_ready             = ready_c[0];
  assign ready_c[STAGES]     = O_ready;
  assign O_valid             = valid_c[STAGES];
  assign O                   = data_bus[BUS_W-1];
  assign tail_ctl_unused     = {op_c[STAGES], inv_c[STAGES], last_c[STAGES]};
`ifdef REDUCE_PIPE_ACCUM_EN
  assign last_c[0] = I_last;
`else
  assign last_c[0] = 1'b1;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_OFF  = level_offset(WIDTH, FANIN, k);
    localparam int IN_W    = level_width(WIDTH, FANIN, k);
    localparam int OUT_OFF = level_offset(WIDTH, FANIN, k + 1);
    localparam int OUT_W   = level_width(WIDTH, FANIN, k + 1);

    reduce_stage #(
      .IN_W  (IN_W),
      .FANIN (FANIN),
      .LAST  (k == STAGES - 1),
      .ACCUM (ACCUM)
    ) u_stage (
      .clk       (CLK),
      .reset     (RESET),
      .in_data   (data_bus[IN_OFF +: IN_W]),
      .in_op     (op_c[k]),
      .in_inv    (inv_c[k]),
      .in_last   (last_c[k]),
      .in_valid  (valid_c[k]),
      .in_ready  (ready_c[k]),
      .out_data  (data_bus[OUT_OFF +: OUT_W]),
      .out_op    (op_c[k+1]),
      .out_inv   (inv_c[k+1]),
      .out_last  (last_c[k+1]),
      .out_valid (valid_c[k+1]),
      .out_ready (ready_c[k+1])
    );
  end

endmodule

// File: tb/tb_reduce_pipe.sv
// tb/tb_reduce_pipe.sv - self-checking bench for reduce_pipe (default and REDUCE_PIPE_ACCUM_EN builds)
module tb_reduce_pipe;

`ifdef REDUCE_PIPE_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] I;
  logic [1:0] OP;
  logic       INV, I_last, I_valid, I_ready, O, O_valid, O_ready;
  logic [4:0] I5;
  logic [1:0] OP5;
  logic       INV5, I5_valid, I5_ready, O5, O5_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_wait = 0;
  int base;

  always #5 CLK = ~CLK;

  reduce_pipe dut (
    .CLK(CLK), .RESET(RESET), .I(I), .OP(OP), .INV(INV),
`ifdef REDUCE_PIPE_ACCUM_EN
    .I_last(I_last),
`endif
    .I_valid(I_valid), .I_ready(I_ready), .O(O), .O_valid(O_valid), .O_ready(O_ready)
  );

  reduce_pipe #(.WIDTH(5), .FANIN(4)) dut5 (
    .CLK(CLK), .RESET(RESET), .I(I5), .OP(OP5), .INV(INV5),
`ifdef REDUCE_PIPE_ACCUM_EN
    .I_last(1'b1),
`endif
    .I_valid(I5_valid), .I_ready(I5_ready), .O(O5), .O_valid(O5_valid), .O_ready(1'b1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic ref_reduce(input logic [7:0] w, input logic [1:0] op);
    case (op)
      2'd0:    return &w;
      2'd2:    return ^w;
      default: return |w;
    endcase
  endfunction

  function automatic logic fold(input logic [1:0] op, input logic a, input logic b);
    case (op)
      2'd0:    return a & b;
      2'd2:    return a ^ b;
      default: return a | b;
    endcase
  endfunction

  typedef struct { logic v; int c; } exp_t;
  exp_t exp_q[$];
  logic got_q[$];
  int   lat_q[$];
  int   ocyc_q[$];
  exp_t mon_e;
  logic mon_r;
  logic pend = 1'b0;
  logic m_acc;
  logic [1:0] m_op;
  logic stall_prev = 1'b0;
  logic stall_o;

  // Scoreboard: every accepted beat (or packet) predicts one result, consumed in order.
  always @(negedge CLK) begin
    cyc++;
    if (RESET) begin
      exp_q.delete();
      pend = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_O_valid", O_valid, 1);
        check("hold_O", O, stall_o);
      end
      if (O_valid && O_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("stream_O", O, mon_e.v);
          got_q.push_back(O);
          lat_q.push_back(cyc - mon_e.c);
          ocyc_q.push_back(cyc);
        end
      end
      if (I_valid && I_ready) begin
        mon_r = ref_reduce(I, OP);
        if (ACC && pend) mon_r = fold(OP, m_acc, mon_r);
        if (!ACC || I_last) begin
          exp_q.push_back('{mon_r ^ INV, cyc});
          pend = 1'b0;
        end else begin
          m_acc = mon_r;
          m_op  = OP;
          pend  = 1'b1;
        end
      end
      stall_prev = O_valid && !O_ready;
      stall_o    = O;
    end
  end

  task automatic beat(input logic [7:0] i, input logic [1:0] op, input logic inv, input logic last);
    bit done;
    done = 0;
    I = i; OP = op; INV = inv; I_last = last; I_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge CLK);
      if (I_ready) done = 1;
      else rdy_wait++;
      @(posedge CLK);
      #1;
    end
    if (!done) check("beat_timeout", 0, 1);
  endtask

  task automatic wait_out(input int n);
    for (int k = 0; k < 100 && got_q.size() < n; k++) begin
      @(negedge CLK);
      #1;
    end
    if (got_q.size() < n) check("wait_timeout", got_q.size(), n);
    @(posedge CLK);
    #1;
  endtask

  task automatic run5(input logic [4:0] i, input logic [1:0] op, input logic inv,
                      input logic want, input string nm);
    I5 = i; OP5 = op; INV5 = inv; I5_valid = 1'b1;
    @(negedge CLK);
    check({nm, "_ready"}, I5_ready, 1);
    @(posedge CLK);
    #1;
    I5_valid = 1'b0;
    @(negedge CLK);
    check({nm, "_early"}, O5_valid, 0);
    @(negedge CLK);
    check({nm, "_valid"}, O5_valid, 1);
    check({nm, "_O"}, O5, want);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; I = '0; OP = '0; INV = 1'b0; I_last = 1'b1; I_valid = 1'b0; O_ready = 1'b1;
    I5 = '0; OP5 = '0; INV5 = 1'b0; I5_valid = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_O_valid", O_valid, 0);
    check("rst_O", O, 0);
    check("rst_O5_valid", O5_valid, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_I_ready", I_ready, 1);
    check("rst_I5_ready", I5_ready, 1);
    @(posedge CLK);
    #1;

    // 8-bit NOR, first-beat latency
    base = got_q.size();
    beat(8'h00, 2'd1, 1'b1, 1'b1);
    beat(8'h10, 2'd1, 1'b1, 1'b1);
    I_valid = 1'b0;
    wait_out(base + 2);
    if (got_q.size() >= base + 2) begin
      check("t1_nor_zero", got_q[base], 1);
      check("t1_latency", lat_q[base], 2);
      check("t1_nor_bit4", got_q[base+1], 0);
    end

    // back-to-back beats at full rate
    base = got_q.size();
    rdy_wait = 0;
    beat(8'hFF, 2'd0, 1'b0, 1'b1);
    beat(8'hFE, 2'd0, 1'b0, 1'b1);
    beat(8'h07, 2'd2, 1'b0, 1'b1);
    I_valid = 1'b0;
    wait_out(base + 3);
    check("t2_no_backpressure", rdy_wait, 0);
    if (got_q.size() >= base + 3) begin
      check("t2_and_ff", got_q[base], 1);
      check("t2_and_fe", got_q[base+1], 0);
      check("t2_xor_07", got_q[base+2], 1);
      check("t2_consecutive", ocyc_q[base+2] - ocyc_q[base], 2);
      check("t2_latency", lat_q[base+2], 2);
    end

    // stall: two accepts fill the pipe, then input is blocked
    base = got_q.size();
    O_ready = 1'b0;
    rdy_wait = 0;
    beat(8'h80, 2'd2, 1'b0, 1'b1);
    beat(8'h00, 2'd0, 1'b0, 1'b1);
    check("t3_two_accepted", rdy_wait, 0);
    I = 8'h00; OP = 2'd1; INV = 1'b1; I_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge CLK);
      check("t3_full_I_ready", I_ready, 0);
      check("t3_held_valid", O_valid, 1);
      @(posedge CLK);
      #1;
    end
    O_ready = 1'b1;
    beat(8'h00, 2'd1, 1'b1, 1'b1);
    I_valid = 1'b0;
    wait_out(base + 3);
    check("t3_count", got_q.size(), base + 3);
    if (got_q.size() >= base + 3) begin
      check("t3_first", got_q[base], 1);
      check("t3_second", got_q[base+1], 0);
      check("t3_third", got_q[base+2], 1);
    end

    // WIDTH=5, FANIN=4: top node has one real bit plus three padded bits
    run5(5'b11111, 2'd0, 1'b0, 1'b1, "w5_and_all");
    run5(5'b01111, 2'd0, 1'b0, 1'b0, "w5_and_top0");
    run5(5'b10000, 2'd2, 1'b0, 1'b1, "w5_xor_top");
    run5(5'b10000, 2'd1, 1'b0, 1'b1, "w5_or_top");
    run5(5'b00000, 2'd1, 1'b1, 1'b1, "w5_nor");

    // reset with two beats in flight
    base = got_q.size();
    O_ready = 1'b0;
    beat(8'hFF, 2'd0, 1'b0, 1'b1);
    beat(8'h01, 2'd1, 1'b0, 1'b1);
    I_valid = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    O_ready = 1'b1;
    @(negedge CLK);
    check("t5_O_valid_after_reset", O_valid, 0);
    check("t5_O_after_reset", O, 0);
    repeat (6) @(negedge CLK);
    check("t5_no_stale_beats", got_q.size(), base);
    @(posedge CLK);
    #1;

`ifdef REDUCE_PIPE_ACCUM_EN
    base = got_q.size();
    beat(8'h00, 2'd1, 1'b0, 1'b0);
    beat(8'h00, 2'd1, 1'b0, 1'b0);
    beat(8'h20, 2'd1, 1'b0, 1'b1);
    I_valid = 1'b0;
    wait_out(base + 1);
    repeat (4) @(posedge CLK);
    #1;
    check("acc_one_output", got_q.size(), base + 1);
    if (got_q.size() >= base + 1) begin
      check("acc_or_pkt", got_q[base], 1);
      check("acc_latency", lat_q[base], 2);
    end
    base = got_q.size();
    beat(8'h00, 2'd1, 1'b0, 1'b0);
    beat(8'h00, 2'd1, 1'b0, 1'b0);
    beat(8'h00, 2'd1, 1'b1, 1'b1);
    I_valid = 1'b0;
    wait_out(base + 1);
    if (got_q.size() >= base + 1) check("acc_nor_pkt", got_q[base], 1);
`endif

    // randomized traffic with random backpressure
    base = got_q.size();
    for (int n = 0; n < 600; n++) begin
      I       = 8'($urandom);
      OP      = (ACC && pend) ? m_op : 2'($urandom);
      INV     = 1'($urandom);
      I_last  = ACC ? ($urandom_range(0, 2) == 0) : 1'b1;
      I_valid = ($urandom_range(0, 3) != 0);
      O_ready = ($urandom_range(0, 3) != 0);
      @(posedge CLK);
      #1;
    end
    I_valid = 1'b0;
    O_ready = 1'b1;
    if (ACC && pend) begin
      beat(8'h00, m_op, 1'b0, 1'b1);
      I_valid = 1'b0;
    end
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge CLK);
    #1;
    check("drain_empty", exp_q.size(), 0);
    check("random_outputs_seen", got_q.size() > base + 20, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reduce_pipe.md
Name: reduce_pipe

Overview:
- Parametrised, pipelined bitwise reduction unit. It is the successor to the fixed 8-bit NOr reducer.
- Reduces an N-bit word to one bit using AND, OR or XOR, with optional final inversion (NAND/NOR/XNOR).
- Built as a FANIN-ary tree. Each tree level is registered, so each stage maps to one LUT4 level on ice40.
- Valid/ready streaming interface on both sides. Sits between datapath blocks and flag or parity consumers.

Parameters:
- WIDTH, 8, input word width in bits; legal range 2..256.
- FANIN, 4, bits combined per tree node per stage; legal values 2..4.
- STAGES, derived, number of registered levels = ceil(log_FANIN(WIDTH)); 2 for the defaults. Not user-overridable.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- I  in  WIDTH  input word.
- OP  in  2  operation per beat: 0=AND, 1=OR, 2=XOR, 3=OR (alias).
- INV  in  1  invert the final result for this beat.
- I_valid  in  1  input beat present.
- I_ready  out  1  unit can accept a beat this cycle.
- O  out  1  reduced result.
- O_valid  out  1  result present.
- O_ready  in  1  downstream accepts the result.

Behaviour:
- Reset:
  - RESET sampled high clears every stage valid bit, so O_valid=0.
  - O=0. Data and OP registers are also cleared to 0.
  - Reset mid-operation discards all in-flight beats, with no partial output.
  - Cycle after RESET deasserts: I_ready=1.
- Handshakes:
  - Input transfer occurs when I_valid and I_ready are both high.
  - Output transfer occurs when O_valid and O_ready are both high.
  - O and O_valid are registered (no combinational path from I to O).
- Pipeline:
  - Stage k holds ceil(WIDTH/FANIN^(k+1)) partial bits, plus valid, OP and INV for that beat.
  - Stage k loads when stage k is empty or stage k advances.
  - The last stage advances when O_ready=1. Ready propagates combinationally back to I_ready = (stage0 empty) OR (stage0 advances).
  - Latency: an accepted beat appears on O after exactly STAGES cycles when unstalled.
  - Throughput: one beat per cycle.
- Stall:
  - While O_valid=1 and O_ready=0, O and O_valid are held stable.
  - Upstream stages keep filling until full; then I_ready=0.
  - No beat is lost or duplicated.
- OP and INV are captured with the beat and travel with it. Changing OP between beats affects only later beats.
- Padding: when a node has fewer than FANIN inputs, the missing bits take the identity value (1 for AND, 0 for OR/XOR).
- INV is applied in the final stage only.
- Simultaneous input and output transfer in the same cycle with a full pipeline is legal and sustains full rate.
- I and OP are ignored when I_valid=0.

Optional Feature:
- Macro REDUCE_PIPE_ACCUM_EN.
- When defined:
  - Adds input port I_last (1 bit).
  - A post-tree accumulator register folds successive beat results with the same op. It starts from the identity of the first beat's OP.
  - O_valid is asserted only for the beat carrying I_last=1. O is then the reduction over all beats of the packet, with INV taken from the last beat.
  - Non-last beats are consumed without producing output.
  - RESET clears the accumulator.
  - Latency is STAGES cycles after the last beat.
- When undefined: no I_last port; every beat produces one output, as described above.

Decomposition:
- Shared package reduce_pkg holds:
  - op enum: OP_AND=0, OP_OR=1, OP_XOR=2, OP_OR_ALT=3;
  - an identity-value function of op;
  - a stage-count function of WIDTH and FANIN.
- One natural sub-module, reduce_stage: one registered tree level with a skid-free valid/ready slice, parameterised by input width. reduce_pipe instantiates it STAGES times in a generate loop.

Test Plan:
- Defaults. After RESET, drive I=8'h00, OP=1, INV=1, with O_ready held at 1 -> O=1 and O_valid=1 exactly 2 cycles later. Then drive I=8'h10 -> O=0 (8-bit NOR).
- Back-to-back beats with O_ready=1:
  - beat 1: I=8'hFF, OP=0, INV=0;
  - beat 2: I=8'hFE, OP=0, INV=0;
  - beat 3: I=8'h07, OP=2, INV=0.
  -> O sequence 1, 0, 1 on three consecutive cycles; I_ready stays 1.
- Stall: fill the pipe, then set O_ready=0 for 5 cycles -> O and O_valid are held stable and I_ready=0 after 2 further accepts. Release O_ready -> all beats emerge in order with none lost.
- WIDTH=5, FANIN=4 padding check:
  - I=5'b11111, OP=0 -> O=1;
  - I=5'b10000, OP=2 -> O=1;
  - I=5'b00000, OP=1, INV=1 -> O=1.
- Assert RESET while 2 beats are in flight -> O_valid=0 on the next cycle and the in-flight beats never appear.
- With REDUCE_PIPE_ACCUM_EN defined, send three beats with OP=1:
  - beats: I=8'h00 (I_last=0), I=8'h00 (I_last=0), I=8'h20 (I_last=1).
  -> Exactly one output, O=1, 2 cycles after the last beat.
  - Repeating the packet with all-zero data and INV=1 on the last beat -> O=1.
